// File: rtl/div_ratio_ctrl.sv
// Glitch-safe sequencer for the integer clock divider's ratio/enable inputs.
// Each update runs disable -> drain two old periods -> load ratio -> re-enable.
module div_ratio_ctrl #(
  parameter int          RATIO_W     = 8,
  parameter int unsigned RESET_RATIO = 1
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic               i_cfg_valid,
  input  logic [RATIO_W-1:0] i_cfg_ratio,
  input  logic               i_cfg_en,
  output logic               o_cfg_ready,
  output logic               o_cfg_done,
  output logic               o_cfg_err,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_clk_en,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [RATIO_W-1:0] RST_RATIO = RATIO_W'(RESET_RATIO);
  localparam logic [RATIO_W:0]   CNT_ONE   = (RATIO_W+1)'(1);

  state_t             state_q, state_d;
  logic [RATIO_W:0]   cnt_q, cnt_d;
  logic [RATIO_W-1:0] ratio_lat_q, ratio_lat_d;
  logic               en_lat_q, en_lat_d;
  logic [RATIO_W-1:0] div_ratio_d;
  logic               clk_en_d, ready_d, done_d, err_d, busy_d;

  logic accept;
  assign accept = i_cfg_valid && o_cfg_ready;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    ratio_lat_d = ratio_lat_q;
    en_lat_d    = en_lat_q;
    div_ratio_d = o_div_ratio;
    clk_en_d    = o_clk_en;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_cfg_ratio == '0) begin
            err_d = 1'b1;
          end else begin
            ratio_lat_d = i_cfg_ratio;
            en_lat_d    = i_cfg_en;
            if (o_clk_en) begin
              // Two old periods, counted down to zero: 2R-1 .. 0 is 2R cycles.
              clk_en_d = 1'b0;
              cnt_d    = {o_div_ratio, 1'b0} - CNT_ONE;
              state_d  = DRAIN;
            end else begin
              div_ratio_d = i_cfg_ratio;
              state_d     = LOAD;
            end
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          div_ratio_d = ratio_lat_q;
          state_d     = LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      LOAD: begin
        clk_en_d = en_lat_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ready/busy are registered copies of the next state so they align with it.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ratio_lat_q <= '0;
      en_lat_q    <= 1'b0;
      o_div_ratio <= RST_RATIO;
      o_clk_en    <= 1'b0;
      o_cfg_ready <= 1'b1;
      o_cfg_done  <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_lat_q <= ratio_lat_d;
      en_lat_q    <= en_lat_d;
      o_div_ratio <= div_ratio_d;
      o_clk_en    <= clk_en_d;
      o_cfg_ready <= ready_d;
      o_cfg_done  <= done_d;
      o_cfg_err   <= err_d;
      o_busy      <= busy_d;
    end
  end

endmodule
